// File: rtl/alu_issue_pipe.sv
// Oldest-first issue of ready RS entries into NUM_ALU registered ALU lanes,
// each lane holding its result until the CDB arbiter accepts it.
module alu_issue_pipe #(
  parameter int NUM_RS    = 8,
  parameter int NUM_ALU   = 2,
  parameter int ROB_IDX_W = 5,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         stall_i,
  input  logic [ROB_IDX_W-1:0]         rob_head_i,
  input  logic [NUM_RS-1:0]            rs_valid_i,
  input  logic [NUM_RS*ROB_IDX_W-1:0]  rs_rob_idx_i,
  input  logic [NUM_RS*4-1:0]          rs_op_i,
  input  logic [NUM_RS*XLEN-1:0]       rs_src1_i,
  input  logic [NUM_RS*XLEN-1:0]       rs_src2_i,
  output logic [NUM_RS-1:0]            rs_clear_o,
  output logic [NUM_ALU-1:0]           res_valid_o,
  input  logic [NUM_ALU-1:0]           res_ready_i,
  output logic [NUM_ALU*ROB_IDX_W-1:0] res_rob_idx_o,
  output logic [NUM_ALU*XLEN-1:0]      res_data_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int SH_W  = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a & b;
      4'd3:    alu_f = a | b;
      4'd4:    alu_f = a ^ b;
      4'd5:    alu_f = a << sh;
      4'd6:    alu_f = a >> sh;
      4'd7:    alu_f = $signed(a) >>> sh;
      4'd8:    alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    alu_f = {{(XLEN-1){1'b0}}, (a < b)};
      default: alu_f = {XLEN{1'b0}};
    endcase
  endfunction

  logic [NUM_ALU-1:0]           res_valid_q, res_valid_d;
  logic [NUM_ALU*ROB_IDX_W-1:0] res_rob_idx_q, res_rob_idx_d;
  logic [NUM_ALU*XLEN-1:0]      res_data_q, res_data_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic                 issue_en;
  logic                 stall_ev;
  logic [NUM_RS-1:0]    taken;
  logic [NUM_ALU-1:0]   lane_go;
  logic [IDX_W-1:0]     lane_sel [NUM_ALU];
  logic [ROB_IDX_W-1:0] age [NUM_RS];

  assign issue_en = !rst_i && !flush_i && !stall_i;

  // Wrap-aware age relative to the ROB head
  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      age[i] = rs_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W] - rob_head_i;
    end
  end

  // Greedy fill of free lanes in ascending order; strict < keeps lower index on age ties
  always_comb begin
    logic                 found;
    logic [IDX_W-1:0]     best;
    logic [ROB_IDX_W-1:0] best_age;
    taken   = {NUM_RS{1'b0}};
    lane_go = {NUM_ALU{1'b0}};
    for (int l = 0; l < NUM_ALU; l++) begin
      lane_sel[l] = {IDX_W{1'b0}};
      found       = 1'b0;
      best        = {IDX_W{1'b0}};
      best_age    = {ROB_IDX_W{1'b0}};
      if (issue_en && (!res_valid_q[l] || res_ready_i[l])) begin
        for (int i = 0; i < NUM_RS; i++) begin
          if (rs_valid_i[i] && !taken[i] && (!found || (age[i] < best_age))) begin
            found    = 1'b1;
            best     = IDX_W'(i);
            best_age = age[i];
          end else begin
            found    = found;
          end
        end
        if (found) begin
          taken[best] = 1'b1;
          lane_go[l]  = 1'b1;
          lane_sel[l] = best;
        end else begin
          lane_go[l]  = 1'b0;
        end
      end else begin
        lane_go[l] = 1'b0;
      end
    end
  end

  assign stall_ev   = issue_en && |(rs_valid_i & ~taken);
  assign rs_clear_o = taken;

  // Lane result registers and stall counter next state
  always_comb begin
    res_valid_d   = res_valid_q;
    res_rob_idx_d = res_rob_idx_q;
    res_data_d    = res_data_q;
    if (flush_i) begin
      res_valid_d = {NUM_ALU{1'b0}};
    end else begin
      for (int l = 0; l < NUM_ALU; l++) begin
        if (lane_go[l]) begin
          res_valid_d[l] = 1'b1;
          res_rob_idx_d[l*ROB_IDX_W +: ROB_IDX_W] =
            rs_rob_idx_i[lane_sel[l]*ROB_IDX_W +: ROB_IDX_W];
          res_data_d[l*XLEN +: XLEN] = alu_f(rs_op_i[lane_sel[l]*4 +: 4],
                                             rs_src1_i[lane_sel[l]*XLEN +: XLEN],
                                             rs_src2_i[lane_sel[l]*XLEN +: XLEN]);
        end else if (res_ready_i[l]) begin
          res_valid_d[l] = 1'b0;
        end else begin
          res_valid_d[l] = res_valid_q[l];
        end
      end
    end
    if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q   <= {NUM_ALU{1'b0}};
      res_rob_idx_q <= {(NUM_ALU*ROB_IDX_W){1'b0}};
      res_data_q    <= {(NUM_ALU*XLEN){1'b0}};
      stall_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      res_valid_q   <= res_valid_d;
      res_rob_idx_q <= res_rob_idx_d;
      res_data_q    <= res_data_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign res_valid_o   = res_valid_q;
  assign res_rob_idx_o = res_rob_idx_q;
  assign res_data_o    = res_data_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Self-checking bench for alu_issue_pipe: directed vectors, corner sequences and
// randomized traffic compared against a rank-based reference model.
module tb_alu_issue_pipe;

  localparam int NRS = 8;
  localparam int NAL = 2;
  localparam int RW  = 5;
  localparam int XL  = 32;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst, flush, stall;
  logic [RW-1:0]   rob_head;
  logic [NRS-1:0]  rs_valid;
  logic [NRS*RW-1:0] rs_rob_idx;
  logic [NRS*4-1:0]  rs_op;
  logic [NRS*XL-1:0] rs_src1, rs_src2;
  logic [NRS-1:0]  rs_clear;
  logic [NAL-1:0]  res_valid, res_ready;
  logic [NAL*RW-1:0] res_rob_idx;
  logic [NAL*XL-1:0] res_data;
  logic [CW-1:0]   stall_cnt;

  always #5 clk = ~clk;

  alu_issue_pipe #(.NUM_RS(NRS), .NUM_ALU(NAL), .ROB_IDX_W(RW), .XLEN(XL), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall), .rob_head_i(rob_head),
    .rs_valid_i(rs_valid), .rs_rob_idx_i(rs_rob_idx), .rs_op_i(rs_op),
    .rs_src1_i(rs_src1), .rs_src2_i(rs_src2), .rs_clear_o(rs_clear),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_rob_idx_o(res_rob_idx),
    .res_data_o(res_data), .stall_cnt_o(stall_cnt)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  logic          m_valid [NAL];
  logic [RW-1:0] m_tag   [NAL];
  logic [XL-1:0] m_data  [NAL];
  logic [CW-1:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XL-1:0] ref_alu(input logic [3:0] op, input logic [XL-1:0] a,
                                            input logic [XL-1:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return XL'($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_entry(input int i, input logic [RW-1:0] rob, input logic [3:0] op,
                           input logic [XL-1:0] a, input logic [XL-1:0] b);
    rs_valid[i]         = 1'b1;
    rs_rob_idx[i*RW +: RW] = rob;
    rs_op[i*4 +: 4]     = op;
    rs_src1[i*XL +: XL] = a;
    rs_src2[i*XL +: XL] = b;
  endtask

  // One clock: model predicts rs_clear by age rank, then the registered outputs.
  // Issued entries are removed from the RS afterwards, as the RS bank would.
  task automatic cycle(input bit do_chk);
    int free_l[$];
    int key [NRS];
    int asg [NAL];
    int nelig, r;
    logic [NRS-1:0] exp_clr;
    logic [RW-1:0] ag;
    bit sev;
    #1;
    exp_clr = '0;
    sev = 1'b0;
    nelig = 0;
    for (int l = 0; l < NAL; l++) asg[l] = -1;
    if (!rst && !stall && !flush) begin
      for (int l = 0; l < NAL; l++) if (!m_valid[l] || res_ready[l]) free_l.push_back(l);
      for (int i = 0; i < NRS; i++) begin
        ag = rs_rob_idx[i*RW +: RW] - rob_head;
        key[i] = int'(ag) * NRS + i;
        if (rs_valid[i]) nelig++;
      end
      for (int i = 0; i < NRS; i++) begin
        if (rs_valid[i]) begin
          r = 0;
          for (int j = 0; j < NRS; j++) if (rs_valid[j] && key[j] < key[i]) r++;
          if (r < free_l.size()) begin
            asg[free_l[r]] = i;
            exp_clr[i] = 1'b1;
          end
        end
      end
      sev = (nelig > free_l.size());
    end
    if (do_chk) chk("rs_clear", 64'(rs_clear), 64'(exp_clr));
    if (rst) begin
      for (int l = 0; l < NAL; l++) begin
        m_valid[l] = 1'b0; m_tag[l] = '0; m_data[l] = '0;
      end
      m_cnt = '0;
    end else begin
      for (int l = 0; l < NAL; l++) begin
        if (flush) m_valid[l] = 1'b0;
        else if (asg[l] >= 0) begin
          m_valid[l] = 1'b1;
          m_tag[l]   = rs_rob_idx[asg[l]*RW +: RW];
          m_data[l]  = ref_alu(rs_op[asg[l]*4 +: 4], rs_src1[asg[l]*XL +: XL],
                               rs_src2[asg[l]*XL +: XL]);
        end else if (res_ready[l]) m_valid[l] = 1'b0;
      end
      if (sev && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    if (do_chk) begin
      for (int l = 0; l < NAL; l++) begin
        chk($sformatf("res_valid[%0d]", l), 64'(res_valid[l]), 64'(m_valid[l]));
        chk($sformatf("res_rob_idx[%0d]", l), 64'(res_rob_idx[l*RW +: RW]), 64'(m_tag[l]));
        chk($sformatf("res_data[%0d]", l), 64'(res_data[l*XL +: XL]), 64'(m_data[l]));
      end
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    end
    rs_valid = rs_valid & ~exp_clr;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    logic [XL-1:0] exp;
  } vec_t;

  vec_t vecs [12];
  logic [XL-1:0] hold_d;
  logic [RW-1:0] hold_t;
  logic [CW-1:0] cnt0;

  initial begin
    vecs[0]  = '{4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[1]  = '{4'd7, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF};
    vecs[2]  = '{4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{4'd5, 32'h0000_0001, 32'd33,        32'h0000_0002};
    vecs[5]  = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[6]  = '{4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vecs[7]  = '{4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vecs[8]  = '{4'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA};
    vecs[9]  = '{4'd6, 32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[10] = '{4'd8, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{4'd12, 32'h1234_5678, 32'h1,        32'h0000_0000};

    for (int l = 0; l < NAL; l++) begin
      m_valid[l] = 1'b0; m_tag[l] = '0; m_data[l] = '0;
    end
    m_cnt = '0;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; rob_head = '0;
    rs_valid = '0; rs_rob_idx = '0; rs_op = '0; rs_src1 = '0; rs_src2 = '0;
    res_ready = 2'b11;
    @(negedge clk);
    rs_valid = 8'hFF;
    cycle(1'b1);
    cycle(1'b1);
    rst = 1'b0;
    rs_valid = '0;
    cycle(1'b1);

    // ALU vectors through lane 0
    for (int v = 0; v < 12; v++) begin
      set_entry(0, 5'(v + 3), vecs[v].op, vecs[v].a, vecs[v].b);
      cycle(1'b1);
      chk($sformatf("vec%0d_data", v), 64'(res_data[XL-1:0]), 64'(vecs[v].exp));
      chk($sformatf("vec%0d_tag", v), 64'(res_rob_idx[RW-1:0]), 64'(v + 3));
      cycle(1'b1);
    end

    // age wrap
    rob_head = 5'd30;
    set_entry(0, 5'd2, 4'd0, 32'd1, 32'd1);
    set_entry(1, 5'd31, 4'd0, 32'd2, 32'd2);
    set_entry(2, 5'd30, 4'd0, 32'd3, 32'd3);
    #1;
    chk("wrap_clear", 64'(rs_clear), 64'h6);
    cycle(1'b1);
    chk("wrap_lane0_tag", 64'(res_rob_idx[4:0]), 64'd30);
    chk("wrap_lane1_tag", 64'(res_rob_idx[9:5]), 64'd31);
    rs_valid = '0;
    cycle(1'b1);
    cycle(1'b1);

    // backpressure on lane 0
    set_entry(0, 5'd1, 4'd0, 32'h100, 32'h23);
    cycle(1'b1);
    hold_d = res_data[XL-1:0];
    hold_t = res_rob_idx[RW-1:0];
    cnt0 = stall_cnt;
    res_ready = 2'b10;
    for (int i = 0; i < 4; i++) set_entry(i + 1, 5'(i + 5), 4'd4, 32'(i), 32'hFF);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1);
      chk("bp_lane0_valid", 64'(res_valid[0]), 64'd1);
      chk("bp_lane0_data", 64'(res_data[XL-1:0]), 64'(hold_d));
      chk("bp_lane0_tag", 64'(res_rob_idx[RW-1:0]), 64'(hold_t));
      chk("bp_stall_cnt", 64'(stall_cnt), 64'(cnt0 + 16'(k)));
    end

    // flush while lane 0 holds
    set_entry(5, 5'd20, 4'd0, 32'd9, 32'd9);
    flush = 1'b1;
    #1;
    chk("flush_clear", 64'(rs_clear), 64'h0);
    cycle(1'b1);
    chk("flush_valid", 64'(res_valid), 64'h0);
    flush = 1'b0;
    rs_valid = '0;
    res_ready = 2'b11;
    cycle(1'b1);

    // back-to-back issue with ready held high
    for (int i = 0; i < 4; i++) set_entry(i, 5'(10 + i), 4'd0, 32'(i), 32'd100);
    cycle(1'b1);
    chk("b2b_valid_1", 64'(res_valid), 64'h3);
    cycle(1'b1);
    chk("b2b_valid_2", 64'(res_valid), 64'h3);
    cycle(1'b1);
    chk("b2b_drain", 64'(res_valid), 64'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NRS; i++) begin
        if (!rs_valid[i] && ($urandom_range(1, 0) == 1))
          set_entry(i, 5'($urandom), 4'($urandom_range(11, 0)), $urandom, $urandom);
      end
      res_ready = 2'($urandom);
      stall = ($urandom_range(9, 0) == 0);
      flush = ($urandom_range(19, 0) == 0);
      if ($urandom_range(7, 0) == 0) rob_head = 5'($urandom);
      cycle(1'b1);
    end
    stall = 1'b0; flush = 1'b0;

    // reset with both lanes holding
    res_ready = 2'b00;
    set_entry(0, 5'd4, 4'd0, 32'd5, 32'd6);
    set_entry(1, 5'd5, 4'd1, 32'd5, 32'd6);
    cycle(1'b1);
    cycle(1'b1);
    chk("pre_rst_valid", 64'(res_valid), 64'h3);
    rst = 1'b1;
    cycle(1'b1);
    chk("rst_valid", 64'(res_valid), 64'h0);
    chk("rst_tag", 64'(res_rob_idx), 64'h0);
    chk("rst_data", 64'(res_data), 64'h0);
    chk("rst_cnt", 64'(stall_cnt), 64'h0);
    rst = 1'b0;

    // stall counter saturation
    res_ready = 2'b11;
    for (int n = 0; n < 65540; n++) begin
      rs_valid = 8'h07;
      cycle(1'b0);
    end
    chk("sat_cnt", 64'(stall_cnt), 64'hFFFF);
    rs_valid = 8'h07;
    cycle(1'b1);
    chk("sat_hold", 64'(stall_cnt), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
